// File: rtl/bp_cfg_bus_initiator.sv
// Host-to-config-bus initiator: one outstanding read/write at a time,
// with a response timeout that reports all-ones data and an error flag.
//
// state  | meaning
// e_idle | ready for a host command
// e_send | request presented on the config bus, waiting for cfg_ready_i
// e_wait | request accepted, waiting for target response or timeout
// e_resp | response held for the host until resp_yumi_i
module bp_cfg_bus_initiator #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int timeout_cycles_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        cmd_v_i,
  input  logic                        cmd_w_i,
  input  logic [cfg_core_width_p-1:0] cmd_core_i,
  input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
  input  logic [cfg_data_width_p-1:0] cmd_data_i,
  output logic                        cmd_ready_o,

  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,

  input  logic                        cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,

  output logic                        resp_v_o,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  input  logic                        resp_yumi_i
);

  localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_cycles_p - 1);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_send = 2'd1,
    e_wait = 2'd2,
    e_resp = 2'd3
  } state_e;

  state_e                      state_r;
  logic                        idle_r;
  logic                        cfg_v_r;
  logic                        cap_w_r;
  logic [cfg_core_width_p-1:0] cap_core_r;
  logic [cfg_addr_width_p-1:0] cap_addr_r;
  logic [cfg_data_width_p-1:0] cap_data_r;
  logic [cnt_width_lp-1:0]     cnt_r;
  logic                        resp_v_r;
  logic [cfg_data_width_p-1:0] resp_data_r;
  logic                        resp_err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      idle_r      <= 1'b1;
      cfg_v_r     <= 1'b0;
      cap_w_r     <= 1'b0;
      cap_core_r  <= '0;
      cap_addr_r  <= '0;
      cap_data_r  <= '0;
      cnt_r       <= '0;
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      unique case (state_r)
        e_idle: begin
          if (cmd_v_i) begin
            cap_w_r    <= cmd_w_i;
            cap_core_r <= cmd_core_i;
            cap_addr_r <= cmd_addr_i;
            // Reads carry no payload on the bus.
            cap_data_r <= cmd_w_i ? cmd_data_i : '0;
            idle_r     <= 1'b0;
            cfg_v_r    <= 1'b1;
            state_r    <= e_send;
          end
        end
        e_send: begin
          if (cfg_ready_i) begin
            cfg_v_r <= 1'b0;
            cnt_r   <= '0;
            state_r <= e_wait;
          end
        end
        e_wait: begin
          // A response arriving on the last timeout cycle still wins.
          if (cfg_resp_v_i) begin
            resp_data_r <= cap_w_r ? '0 : cfg_resp_data_i;
            resp_err_r  <= 1'b0;
            resp_v_r    <= 1'b1;
            state_r     <= e_resp;
          end else if (cnt_r == cnt_last_lp) begin
            resp_data_r <= '1;
            resp_err_r  <= 1'b1;
            resp_v_r    <= 1'b1;
            state_r     <= e_resp;
          end
          if (cnt_r != '1) begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        e_resp: begin
          if (resp_yumi_i) begin
            resp_v_r <= 1'b0;
            idle_r   <= 1'b1;
            state_r  <= e_idle;
          end
        end
        default: begin
          state_r <= e_idle;
          idle_r  <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = idle_r & ~reset_i;
  assign cfg_v_o     = cfg_v_r;
  assign cfg_w_o     = cap_w_r;
  assign cfg_core_o  = cap_core_r;
  assign cfg_addr_o  = cap_addr_r;
  assign cfg_data_o  = cap_data_r;
  assign resp_v_o    = resp_v_r;
  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;

endmodule

// File: tb/tb_bp_cfg_bus_initiator.sv
// Directed bench for bp_cfg_bus_initiator built with a short timeout of 4 cycles.
module tb_bp_cfg_bus_initiator;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_v_i, cmd_w_i;
  logic [7:0]  cmd_core_i;
  logic [15:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        cmd_ready_o;
  logic        cfg_v_o, cfg_w_o;
  logic [7:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_i;
  logic        cfg_resp_v_i;
  logic [31:0] cfg_resp_data_i;
  logic        resp_v_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        resp_yumi_i;

  int checks = 0;
  int errors = 0;

  bp_cfg_bus_initiator #(
    .cfg_core_width_p(8),
    .cfg_addr_width_p(16),
    .cfg_data_width_p(32),
    .timeout_cycles_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_w_i(cmd_w_i), .cmd_core_i(cmd_core_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
    .cfg_v_o(cfg_v_o), .cfg_w_o(cfg_w_o), .cfg_core_o(cfg_core_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
    .cfg_resp_v_i(cfg_resp_v_i), .cfg_resp_data_i(cfg_resp_data_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_yumi_i(resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] core, input logic [15:0] addr,
                          input logic [31:0] data);
    cmd_v_i = 1'b1; cmd_w_i = w; cmd_core_i = core; cmd_addr_i = addr; cmd_data_i = data;
    step();
    cmd_v_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; cmd_v_i = 1'b1; cmd_w_i = 1'b1; cmd_core_i = 8'h11;
    cmd_addr_i = 16'h2222; cmd_data_i = 32'h33333333;
    cfg_ready_i = 1'b0; cfg_resp_v_i = 1'b0; cfg_resp_data_i = '0; resp_yumi_i = 1'b0;
    #1;
    chk("ready_in_reset_t0", 32'(cmd_ready_o), 32'd0);
    step(); step();
    chk("ready_in_reset", 32'(cmd_ready_o), 32'd0);
    chk("rst_cfg_v", 32'(cfg_v_o), 32'd0);
    chk("rst_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_resp_data", resp_data_o, 32'd0);
    chk("rst_cap_addr", 32'(cfg_addr_o), 32'd0);
    chk("rst_cap_core", 32'(cfg_core_o), 32'd0);
    reset_i = 1'b0; cmd_v_i = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_ready_o), 32'd1);
    // Stray yumi in idle does nothing.
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("idle_cfg_v", 32'(cfg_v_o), 32'd0);
    chk("idle_ready", 32'(cmd_ready_o), 32'd1);

    // Read: ready in the first send cycle, response two cycles after handshake.
    send_cmd(1'b0, 8'd3, 16'h0010, 32'hAAAA5555);
    chk("rd_cfg_v", 32'(cfg_v_o), 32'd1);
    chk("rd_cfg_w", 32'(cfg_w_o), 32'd0);
    chk("rd_core", 32'(cfg_core_o), 32'd3);
    chk("rd_addr", 32'(cfg_addr_o), 32'h10);
    chk("rd_data_zero", cfg_data_o, 32'd0);
    chk("rd_ready_busy", 32'(cmd_ready_o), 32'd0);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    chk("rd_cfg_v_drop", 32'(cfg_v_o), 32'd0);
    step();
    cfg_resp_v_i = 1'b1; cfg_resp_data_i = 32'hDEADBEEF;
    step();
    cfg_resp_v_i = 1'b0;
    chk("rd_resp_v", 32'(resp_v_o), 32'd1);
    chk("rd_resp_data", resp_data_o, 32'hDEADBEEF);
    chk("rd_resp_err", 32'(resp_err_o), 32'd0);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("rd_done_resp_v", 32'(resp_v_o), 32'd0);
    chk("rd_done_ready", 32'(cmd_ready_o), 32'd1);

    // Write with five cycles of backpressure and a spurious response while in send.
    send_cmd(1'b1, 8'h5A, 16'hBEEF, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      cfg_resp_v_i = (i == 2); cfg_resp_data_i = 32'h0BAD0BAD;
      chk("wr_hold_v", 32'(cfg_v_o), 32'd1);
      chk("wr_hold_data", cfg_data_o, 32'h12345678);
      chk("wr_hold_addr", 32'(cfg_addr_o), 32'hBEEF);
      step();
    end
    cfg_resp_v_i = 1'b0;
    chk("wr_hold_v6", 32'(cfg_v_o), 32'd1);
    chk("wr_cfg_w", 32'(cfg_w_o), 32'd1);
    chk("wr_core", 32'(cfg_core_o), 32'h5A);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    chk("wr_cfg_v_drop", 32'(cfg_v_o), 32'd0);
    cfg_resp_v_i = 1'b1; cfg_resp_data_i = 32'hCAFEF00D;
    step();
    cfg_resp_v_i = 1'b0;
    chk("wr_resp_v", 32'(resp_v_o), 32'd1);
    chk("wr_resp_data", resp_data_o, 32'd0);
    chk("wr_resp_err", 32'(resp_err_o), 32'd0);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;

    // Timeout: no response, resp_v_o appears 5 cycles after the handshake cycle.
    send_cmd(1'b0, 8'd7, 16'h0100, 32'd0);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_not_yet", 32'(resp_v_o), 32'd0);
      step();
    end
    chk("to_resp_v", 32'(resp_v_o), 32'd1);
    chk("to_resp_err", 32'(resp_err_o), 32'd1);
    chk("to_resp_data", resp_data_o, 32'hFFFFFFFF);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;

    // Response on the final timeout cycle takes priority.
    send_cmd(1'b0, 8'd8, 16'h0200, 32'd0);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    step(); step(); step();
    cfg_resp_v_i = 1'b1; cfg_resp_data_i = 32'h5;
    step();
    cfg_resp_v_i = 1'b0;
    chk("sim_resp_v", 32'(resp_v_o), 32'd1);
    chk("sim_resp_err", 32'(resp_err_o), 32'd0);
    chk("sim_resp_data", resp_data_o, 32'h5);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;

    // Reset in e_wait, then a late response must not surface.
    send_cmd(1'b0, 8'd9, 16'h0300, 32'd0);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #0;
    chk("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_mid_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_mid_resp_data", resp_data_o, 32'd0);
    cfg_resp_v_i = 1'b1; cfg_resp_data_i = 32'h77;
    step();
    cfg_resp_v_i = 1'b0;
    chk("late_resp_v", 32'(resp_v_o), 32'd0);
    chk("late_ready", 32'(cmd_ready_o), 32'd1);
    step();
    chk("late_resp_v2", 32'(resp_v_o), 32'd0);

    // Response held 10 cycles with a pending command and a spurious target response.
    send_cmd(1'b0, 8'd4, 16'h0400, 32'd0);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    cfg_resp_v_i = 1'b1; cfg_resp_data_i = 32'h11223344;
    step();
    cfg_resp_v_i = 1'b0;
    cmd_v_i = 1'b1; cmd_w_i = 1'b1; cmd_core_i = 8'h21; cmd_addr_i = 16'h0500;
    cmd_data_i = 32'h0000ABCD;
    for (int i = 0; i < 10; i++) begin
      cfg_resp_v_i = (i == 3); cfg_resp_data_i = 32'h99;
      chk("hold_resp_v", 32'(resp_v_o), 32'd1);
      chk("hold_resp_data", resp_data_o, 32'h11223344);
      chk("hold_resp_err", 32'(resp_err_o), 32'd0);
      chk("hold_ready", 32'(cmd_ready_o), 32'd0);
      step();
    end
    cfg_resp_v_i = 1'b0;
    chk("hold_after_spur", resp_data_o, 32'h11223344);
    resp_yumi_i = 1'b1;
    chk("yumi_cycle_ready", 32'(cmd_ready_o), 32'd0);
    step();
    resp_yumi_i = 1'b0;
    chk("post_yumi_ready", 32'(cmd_ready_o), 32'd1);
    chk("post_yumi_cfg_v", 32'(cfg_v_o), 32'd0);
    step();
    cmd_v_i = 1'b0;
    chk("next_cmd_cfg_v", 32'(cfg_v_o), 32'd1);
    chk("next_cmd_addr", 32'(cfg_addr_o), 32'h0500);
    chk("next_cmd_data", cfg_data_o, 32'h0000ABCD);
    cfg_ready_i = 1'b1;
    step();
    cfg_ready_i = 1'b0;
    cfg_resp_v_i = 1'b1;
    step();
    cfg_resp_v_i = 1'b0;
    chk("next_resp_data", resp_data_o, 32'd0);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("final_ready", 32'(cmd_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cfg_bus_initiator.md
BP_CFG_BUS_INITIATOR -- requirements
Module: bp_cfg_bus_initiator

Interface
REQ-001 SHALL have parameter cfg_core_width_p, default 8, meaning the width of the target core id.
REQ-002 SHALL have parameter cfg_addr_width_p, default 16, meaning the width of the config register address.
REQ-003 SHALL have parameter cfg_data_width_p, default 32, meaning the width of config data.
REQ-004 SHALL have parameter timeout_cycles_p, default 64, meaning the maximum cycles to wait for a target response (minimum 1).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on the rising edge of clk_i.
REQ-006 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port cmd_v_i, input, 1 bit: a host command is valid.
REQ-008 SHALL have port cmd_w_i, input, 1 bit: 1 means write, 0 means read.
REQ-009 SHALL have ports cmd_core_i, cmd_addr_i and cmd_data_i, inputs, widths cfg_core_width_p, cfg_addr_width_p and cfg_data_width_p: the command fields.
REQ-010 SHALL have port cmd_ready_o, output, 1 bit: the block can accept a command.
REQ-011 SHALL have ports cfg_v_o (1) and cfg_w_o (1), outputs: the config bus request valid and the write flag.
REQ-012 SHALL have ports cfg_core_o, cfg_addr_o and cfg_data_o, outputs, the widths above: the config bus request fields.
REQ-013 SHALL have port cfg_ready_i, input, 1 bit: the target accepts the request.
REQ-014 SHALL have ports cfg_resp_v_i (input, 1 bit) and cfg_resp_data_i (input, cfg_data_width_p): the target response.
REQ-015 SHALL have ports resp_v_o (output, 1), resp_data_o (output, cfg_data_width_p), resp_err_o (output, 1) and resp_yumi_i (input, 1): the host response channel.

Function
REQ-016 SHALL allow at most one outstanding transaction.
REQ-017 SHALL implement the states e_idle, e_send, e_wait and e_resp.
REQ-018 SHALL drive cmd_ready_o=1 only in e_idle.
REQ-019 SHALL, when cmd_v_i&cmd_ready_o, capture all cmd fields in the same cycle and go to e_send on the next cycle.
REQ-020 SHALL, in e_send, drive cfg_v_o=1 with the captured fields, held stable until cfg_ready_i.
REQ-021 SHALL, on cfg_v_o&cfg_ready_i, go to e_wait and clear the timeout counter to 0.
REQ-022 SHALL drive cfg_v_o=0 in every state other than e_send.
REQ-023 SHALL drive cfg_data_o=0 for reads.
REQ-024 SHALL, in e_wait, increment the counter each cycle; the counter SHALL be clog2(timeout_cycles_p+1) bits and SHALL saturate (never wrap).
REQ-025 SHALL, in e_wait with cfg_resp_v_i=1, latch the response data as follows: reads take cfg_resp_data_i; writes force the data to 0 (the response serves as an ack only). It SHALL then set err=0 and go to e_resp.
REQ-026 SHALL, in e_wait, when the counter equals timeout_cycles_p-1 with no cfg_resp_v_i, set data to all-ones, set err=1, and go to e_resp.
REQ-027 SHALL give the response priority over the timeout when both occur in the same cycle (err=0).
REQ-028 SHALL ignore cfg_resp_v_i in e_idle, e_send and e_resp, with no state change and no data capture.
REQ-029 SHALL, in e_resp, hold resp_v_o=1 with stable resp_data_o/resp_err_o until resp_yumi_i, then return to e_idle.
REQ-030 SHALL have resp_yumi_i asserted only while resp_v_o=1; resp_yumi_i outside e_resp SHALL be ignored.
REQ-031 SHALL NOT accept a new command in the same cycle as resp_yumi_i; cmd_ready_o rises the following cycle, giving a minimum of 4 cycles from command to the next command.
REQ-032 SHALL NOT allow the timeout to fire in e_send; a stalled cfg_ready_i holds the block in e_send indefinitely.

Reset
REQ-033 SHALL, on reset_i=1 at a clock edge, enter e_idle regardless of the current state, abandoning any in-flight transaction without emitting a response.
REQ-034 SHALL drive the following output values during and immediately after reset: cmd_ready_o=0 while reset_i=1 and 1 thereafter; cfg_v_o=0; resp_v_o=0; resp_err_o=0; resp_data_o=0; the counter=0; the captured fields=0.
REQ-035 SHALL ignore cmd_v_i while reset_i=1.

Verification
REQ-036 SHALL cover a read: cmd read core=3 addr=0x0010, cfg_ready_i the same cycle, cfg_resp_v_i 2 cycles later with 0xDEADBEEF -> resp_v_o=1, resp_data_o=0xDEADBEEF, resp_err_o=0, and cfg_data_o=0 during e_send.
REQ-037 SHALL cover a write with backpressure: write data=0x12345678, cfg_ready_i low for 5 cycles -> cfg_v_o held 6 cycles with stable fields; after the resp, resp_data_o=0 and resp_err_o=0.
REQ-038 SHALL cover a timeout: timeout_cycles_p=4 with no target response -> resp_v_o exactly 5 cycles after the cfg handshake cycle, resp_err_o=1, resp_data_o=0xFFFFFFFF.
REQ-039 SHALL cover a simultaneous response and timeout: cfg_resp_v_i with 0x5 on the final timeout cycle -> resp_err_o=0, resp_data_o=0x5.
REQ-040 SHALL cover reset mid-operation: reset_i pulsed in e_wait, then a late cfg_resp_v_i -> no resp_v_o, and cmd_ready_o=1 the cycle after reset deasserts.
REQ-041 SHALL cover response hold and a spurious response: resp_yumi_i withheld for 10 cycles while cmd_v_i=1 and a spurious cfg_resp_v_i is applied -> resp fields stable, cmd_ready_o=0, and the spurious response is ignored.
